instr_queue: RTL and testbench

//   Parametrised fetch-to-decode instruction buffer: replaces the single-entry

---
 rtl/instr_queue_pkg.sv | 13 +
 rtl/instr_queue_if.sv | 25 ++
 rtl/instr_queue.sv | 77 +++++++
 tb/tb_instr_queue.sv | 130 +++++++++++++
 4 files changed

// File: rtl/instr_queue_pkg.sv
// Shared fetch/decode definitions: default datapath width, the bubble
// instruction and the {instr, pc} entry layout.
package instr_queue_pkg;

    localparam int unsigned XLEN_DEF      = 32;
    localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN_DEF-1:0] instr;
        logic [XLEN_DEF-1:0] pc;
    } instr_entry_t;

endpackage

// File: rtl/instr_queue_if.sv
// Fetch-side and decode-side valid/ready handshake of the instruction queue.
interface instr_queue_if
    import instr_queue_pkg::*;
#(
    parameter int unsigned XLEN = XLEN_DEF
);
    logic            in_valid;
    logic            in_ready;
    logic [XLEN-1:0] in_instr;
    logic [XLEN-1:0] in_pc;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_instr;
    logic [XLEN-1:0] out_pc;

    modport master (
        output in_valid, in_instr, in_pc, out_ready,
        input  in_ready, out_valid, out_instr, out_pc
    );

    modport slave (
        input  in_valid, in_instr, in_pc, out_ready,
        output in_ready, out_valid, out_instr, out_pc
    );
endinterface

// File: rtl/instr_queue.sv
// DEPTH-entry fetch-to-decode FIFO of {instr, pc}; shows NOP_INSTR to decode
// while empty, discards everything on flush or reset.
module instr_queue
    import instr_queue_pkg::*;
#(
    parameter int unsigned     XLEN      = XLEN_DEF,
    parameter int unsigned     DEPTH     = 4,
    parameter logic [XLEN-1:0] NOP_INSTR = XLEN'(NOP_INSTR_DEF)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    instr_queue_if.slave             q,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW      = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = 1;

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
    } entry_t;

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_check
        $error("instr_queue: DEPTH must be a power of two and >= 2");
    end

    entry_t      mem_q [DEPTH];
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic        empty, full, push, pop;
    entry_t      head;

    // Extra wrap bit distinguishes full from empty when the index bits match.
    assign empty = (rd_ptr_q == wr_ptr_q);
    assign full  = (rd_ptr_q[AW-1:0] == wr_ptr_q[AW-1:0]) && (rd_ptr_q[AW] != wr_ptr_q[AW]);
    assign push  = q.in_valid  && !full  && !flush;
    assign pop   = !empty && q.out_ready && !flush;
    assign head  = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
        end
    end

    // Storage is deliberately not reset so it can map onto distributed RAM.
    always_ff @(posedge clk) begin
        if (push && !reset) begin
            mem_q[wr_ptr_q[AW-1:0]] <= '{instr: q.in_instr, pc: q.in_pc};
        end
    end

    assign q.in_ready  = !full;
    assign q.out_valid = !empty;
    assign q.out_instr = empty ? NOP_INSTR : head.instr;
    assign q.out_pc    = empty ? '0        : head.pc;
    assign count       = wr_ptr_q - rd_ptr_q;

endmodule

// File: tb/tb_instr_queue.sv
// Randomised and directed checks of instr_queue against a queue-based model.
module tb_instr_queue;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned DEPTH = 4;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic clk = 1'b0;
    logic reset, flush;
    logic [$clog2(DEPTH):0] count;

    instr_queue_if #(.XLEN(XLEN)) bus ();

    instr_queue #(.XLEN(XLEN), .DEPTH(DEPTH), .NOP_INSTR(NOP)) dut (
        .clk   (clk),
        .reset (reset),
        .flush (flush),
        .q     (bus.slave),
        .count (count)
    );

    always #5 clk = ~clk;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    // Reference: each element is {instr, pc}, head at index 0.
    logic [63:0] model [$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_outputs();
        logic [63:0] hd;
        hd = (model.size() > 0) ? model[0] : 64'h0;
        chk("count",     64'(count),         64'(model.size()));
        chk("out_valid", 64'(bus.out_valid), 64'(model.size() > 0));
        chk("in_ready",  64'(bus.in_ready),  64'(model.size() < DEPTH));
        chk("out_instr", 64'(bus.out_instr), (model.size() > 0) ? 64'(hd[63:32]) : 64'(NOP));
        chk("out_pc",    64'(bus.out_pc),    (model.size() > 0) ? 64'(hd[31:0])  : 64'h0);
    endtask

    // Drive one cycle of inputs, advance the model by the queue rules, then check.
    task automatic cycle(input logic rst, input logic fl, input logic iv,
                         input logic [31:0] ii, input logic [31:0] ip, input logic ordy);
        bit can_push, can_pop;
        reset         = rst;
        flush         = fl;
        bus.in_valid  = iv;
        bus.in_instr  = ii;
        bus.in_pc     = ip;
        bus.out_ready = ordy;
        @(posedge clk);
        if (rst || fl) begin
            model.delete();
        end else begin
            can_push = iv && (model.size() < DEPTH);
            can_pop  = ordy && (model.size() > 0);
            if (can_pop)  void'(model.pop_front());
            if (can_push) model.push_back({ii, ip});
        end
        #1;
        check_outputs();
    endtask

    task automatic idle(input logic ordy);
        cycle(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, ordy);
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0;
        bus.in_valid = 1'b0; bus.in_instr = '0; bus.in_pc = '0; bus.out_ready = 1'b0;

        // Reset for two cycles
        cycle(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        cycle(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        chk("rst_instr", 64'(bus.out_instr), 64'h13);
        chk("rst_ready", 64'(bus.in_ready), 64'h1);

        // Fill with decode stalled, fifth push must be dropped
        for (int i = 0; i < 5; i++)
            cycle(1'b0, 1'b0, 1'b1, 32'hA0 + 32'(i), 32'(4 * i), 1'b0);
        chk("fill_count", 64'(count), 64'd4);
        chk("fill_ready", 64'(bus.in_ready), 64'd0);
        chk("fill_head",  64'(bus.out_instr), 64'hA0);
        for (int i = 0; i < 5; i++) idle(1'b1);
        chk("drain_nop", 64'(bus.out_instr), 64'h13);

        // Simultaneous push/pop at occupancy 2 across the pointer wrap
        cycle(1'b0, 1'b0, 1'b1, 32'hB0, 32'h100, 1'b0);
        cycle(1'b0, 1'b0, 1'b1, 32'hB1, 32'h104, 1'b0);
        for (int i = 2; i < 12; i++) begin
            cycle(1'b0, 1'b0, 1'b1, 32'hB0 + 32'(i), 32'h100 + 32'(4 * i), 1'b1);
            chk("sim_count", 64'(count), 64'd2);
        end
        idle(1'b1);
        idle(1'b1);

        // Flush at occupancy 3 with a concurrent push
        for (int i = 0; i < 3; i++)
            cycle(1'b0, 1'b0, 1'b1, 32'hC0 + 32'(i), 32'h200 + 32'(4 * i), 1'b0);
        cycle(1'b0, 1'b1, 1'b1, 32'hDEAD, 32'h300, 1'b1);
        chk("flush_count", 64'(count), 64'd0);
        for (int i = 0; i < 3; i++) idle(1'b1);

        // Mid-stream reset concurrent with a pop
        cycle(1'b0, 1'b0, 1'b1, 32'hE0, 32'h400, 1'b0);
        cycle(1'b0, 1'b0, 1'b1, 32'hE1, 32'h404, 1'b0);
        cycle(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
        chk("mrst_count", 64'(count), 64'd0);
        chk("mrst_pc",    64'(bus.out_pc), 64'd0);
        idle(1'b1);

        // Random traffic with occasional redirects and resets
        for (int i = 0; i < 10000; i++) begin
            cycle(($urandom_range(0, 999) == 0), ($urandom_range(0, 199) == 0),
                  1'($urandom), $urandom, $urandom, 1'($urandom));
            chk("count_range", 64'(count <= DEPTH), 64'd1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
